// File: rtl/ble_tx_packetizer.sv
// BLE link-layer transmit framer: preamble, access address, PDU and CRC24 sent one bit per sym_tick.
// Optional data whitening of the PDU and CRC is compiled in with macro BLE_TX_WHITEN_EN.
module ble_tx_packetizer #(
   parameter logic [31:0] ACCESS_ADDR = 32'h8E89BED6,
   parameter logic [23:0] CRC_INIT    = 24'h555555
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sym_tick,
   input  logic       start,
   input  logic [7:0] pdu_len,
   input  logic [5:0] channel,
   input  logic [7:0] byte_data,
   input  logic       byte_valid,
   output logic       byte_ready,
   output logic       tx_bit,
   output logic       tx_en,
   output logic       busy,
   output logic       done,
   output logic       underrun
);

   typedef enum logic [2:0] {IDLE, PRE, AA, PDU, CRC} state_t;

   localparam logic [7:0]  PREAMBLE = ACCESS_ADDR[0] ? 8'h55 : 8'hAA;
   localparam logic [23:0] CRC_POLY = 24'h00065B;

   state_t      state_q, state_d;
   logic        tx_bit_q, tx_bit_d;
   logic        tx_en_q, tx_en_d;
   logic        done_q, done_d;
   logic        underrun_q, underrun_d;
   logic [5:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  byte_cnt_q, byte_cnt_d;
   logic [7:0]  req_cnt_q, req_cnt_d;
   logic [7:0]  len_q, len_d;
   logic [31:0] sh_q, sh_d;
   logic [23:0] crc_q, crc_d;
   logic [7:0]  hold_q, hold_d;
   logic        hold_full_q, hold_full_d;

   logic        take;
   logic        load_byte;
   logic        white_bit;
   logic        wht_seed;
   logic        wht_step;

   function automatic logic [23:0] crc_next(input logic [23:0] c, input logic d);
      logic fb;
      fb = c[23] ^ d;
      return {c[22:0], 1'b0} ^ (fb ? CRC_POLY : 24'h000000);
   endfunction

   // Byte handshake: a byte moves into the holding buffer on any clk edge where
   // byte_valid && byte_ready; byte_valid without byte_ready is simply ignored.
   assign byte_ready = !hold_full_q && (req_cnt_q < len_q) &&
                       ((state_q == PRE) || (state_q == AA) || (state_q == PDU));
   assign take       = byte_valid && byte_ready;

   always_comb begin
      state_d     = state_q;
      tx_bit_d    = tx_bit_q;
      tx_en_d     = tx_en_q;
      done_d      = 1'b0;
      underrun_d  = 1'b0;
      bit_cnt_d   = bit_cnt_q;
      byte_cnt_d  = byte_cnt_q;
      req_cnt_d   = req_cnt_q;
      len_d       = len_q;
      sh_d        = sh_q;
      crc_d       = crc_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      load_byte   = 1'b0;
      wht_seed    = 1'b0;
      wht_step    = 1'b0;

      if (take) begin
         hold_d      = byte_data;
         hold_full_d = 1'b1;
         req_cnt_d   = req_cnt_q + 8'd1;
      end

      case (state_q)
         IDLE: begin
            if (start && (pdu_len >= 8'd2)) begin
               state_d     = PRE;
               len_d       = pdu_len;
               sh_d        = {24'h000000, PREAMBLE};
               crc_d       = CRC_INIT;
               bit_cnt_d   = 6'd0;
               byte_cnt_d  = 8'd0;
               req_cnt_d   = 8'd0;
               hold_full_d = 1'b0;
               wht_seed    = 1'b1;
            end
         end
         PRE: begin
            if (sym_tick) begin
               tx_en_d = 1'b1;
               if (bit_cnt_q == 6'd8) begin
                  state_d   = AA;
                  tx_bit_d  = ACCESS_ADDR[0];
                  sh_d      = {1'b0, ACCESS_ADDR[31:1]};
                  bit_cnt_d = 6'd1;
               end else begin
                  tx_bit_d  = sh_q[0];
                  sh_d      = {1'b0, sh_q[31:1]};
                  bit_cnt_d = bit_cnt_q + 6'd1;
               end
            end
         end
         AA: begin
            if (sym_tick) begin
               if (bit_cnt_q != 6'd32) begin
                  tx_bit_d  = sh_q[0];
                  sh_d      = {1'b0, sh_q[31:1]};
                  bit_cnt_d = bit_cnt_q + 6'd1;
               end else begin
                  load_byte = 1'b1;
               end
            end
         end
         PDU: begin
            if (sym_tick) begin
               if (bit_cnt_q != 6'd8) begin
                  tx_bit_d  = sh_q[0] ^ white_bit;
                  crc_d     = crc_next(crc_q, sh_q[0]);
                  sh_d      = {1'b0, sh_q[31:1]};
                  bit_cnt_d = bit_cnt_q + 6'd1;
                  wht_step  = 1'b1;
               end else if (byte_cnt_q != len_q) begin
                  load_byte = 1'b1;
               end else begin
                  state_d   = CRC;
                  tx_bit_d  = crc_q[23] ^ white_bit;
                  crc_d     = {crc_q[22:0], 1'b0};
                  bit_cnt_d = 6'd1;
                  wht_step  = 1'b1;
               end
            end
         end
         CRC: begin
            // The cycle carrying the done pulse still reads busy; IDLE follows it.
            if (done_q) begin
               state_d    = IDLE;
               bit_cnt_d  = 6'd0;
               byte_cnt_d = 8'd0;
               req_cnt_d  = 8'd0;
            end else if (sym_tick) begin
               if (bit_cnt_q != 6'd24) begin
                  tx_bit_d  = crc_q[23] ^ white_bit;
                  crc_d     = {crc_q[22:0], 1'b0};
                  bit_cnt_d = bit_cnt_q + 6'd1;
                  wht_step  = 1'b1;
               end else begin
                  tx_en_d  = 1'b0;
                  tx_bit_d = 1'b0;
                  done_d   = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Byte boundary: start the next PDU byte from the buffer, or abort if it is empty.
      if (load_byte) begin
         if (hold_full_q) begin
            state_d     = PDU;
            tx_bit_d    = hold_q[0] ^ white_bit;
            crc_d       = crc_next(crc_q, hold_q[0]);
            sh_d        = {25'h0000000, hold_q[7:1]};
            hold_full_d = 1'b0;
            byte_cnt_d  = byte_cnt_q + 8'd1;
            bit_cnt_d   = 6'd1;
            wht_step    = 1'b1;
         end else begin
            state_d     = IDLE;
            tx_en_d     = 1'b0;
            tx_bit_d    = 1'b0;
            underrun_d  = 1'b1;
            hold_full_d = 1'b0;
            bit_cnt_d   = 6'd0;
            byte_cnt_d  = 8'd0;
            req_cnt_d   = 8'd0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         tx_bit_q    <= 1'b0;
         tx_en_q     <= 1'b0;
         done_q      <= 1'b0;
         underrun_q  <= 1'b0;
         bit_cnt_q   <= 6'd0;
         byte_cnt_q  <= 8'd0;
         req_cnt_q   <= 8'd0;
         len_q       <= 8'd0;
         sh_q        <= 32'h00000000;
         crc_q       <= 24'h000000;
         hold_q      <= 8'h00;
         hold_full_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tx_bit_q    <= tx_bit_d;
         tx_en_q     <= tx_en_d;
         done_q      <= done_d;
         underrun_q  <= underrun_d;
         bit_cnt_q   <= bit_cnt_d;
         byte_cnt_q  <= byte_cnt_d;
         req_cnt_q   <= req_cnt_d;
         len_q       <= len_d;
         sh_q        <= sh_d;
         crc_q       <= crc_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
      end
   end

`ifdef BLE_TX_WHITEN_EN
   // Whitening LFSR x^7+x^4+1, advanced once per PDU/CRC bit sent.
   logic [6:0] wht_q, wht_d;

   always_comb begin
      wht_d = wht_q;
      if (wht_seed) begin
         wht_d = {1'b1, channel};
      end else if (wht_step) begin
         wht_d = {wht_q[5:0], wht_q[6]} ^ {2'b00, wht_q[6], 4'b0000};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wht_q <= 7'h00;
      end else begin
         wht_q <= wht_d;
      end
   end

   assign white_bit = wht_q[6];
`else
   logic unused_whiten;
   assign unused_whiten = ^{channel, wht_seed, wht_step};
   assign white_bit     = 1'b0;
`endif

   assign tx_bit   = tx_bit_q;
   assign tx_en    = tx_en_q;
   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_ble_tx_packetizer.sv
// Bench for ble_tx_packetizer: random frames checked against a bit-list reference model.
// Honours BLE_TX_WHITEN_EN so the model whitens exactly when the design does.
`timescale 1ns/1ps
module tb_ble_tx_packetizer;

   localparam logic [31:0] AA_REF   = 32'h8E89BED6;
   localparam logic [23:0] SEED_REF = 24'h555555;
`ifdef BLE_TX_WHITEN_EN
   localparam bit WHITEN = 1'b1;
`else
   localparam bit WHITEN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       sym_tick;
   logic       start;
   logic [7:0] pdu_len;
   logic [5:0] channel;
   logic [7:0] byte_data;
   logic       byte_valid;
   logic       byte_ready;
   logic       tx_bit;
   logic       tx_en;
   logic       busy;
   logic       done;
   logic       underrun;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [0:0] exp_q[$];
   logic [0:0] cap_q[$];
   logic [7:0] pdu_mem [0:255];

   int n_done, n_underrun, n_accepted, n_bit_off_err;
   bit timed_out, saw_fall, fall_done, fall_underrun, busy_at_done, busy_after_done;

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   ble_tx_packetizer dut (
      .clk        (clk),
      .rst        (rst),
      .sym_tick   (sym_tick),
      .start      (start),
      .pdu_len    (pdu_len),
      .channel    (channel),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .tx_bit     (tx_bit),
      .tx_en      (tx_en),
      .busy       (busy),
      .done       (done),
      .underrun   (underrun)
   );

   // Reference model: the whole on-air bit list for a frame of len bytes from pdu_mem.
   function automatic void build_exp(input int len, input logic [5:0] chan);
      logic [7:0]  pre;
      logic [23:0] crc;
      logic [6:0]  w;
      logic        d, fb;
      exp_q.delete();
      pre = AA_REF[0] ? 8'h55 : 8'hAA;
      for (int i = 0; i < 8; i++) exp_q.push_back(pre[i]);
      for (int i = 0; i < 32; i++) exp_q.push_back(AA_REF[i]);
      crc = SEED_REF;
      w   = {1'b1, chan};
      for (int n = 0; n < len; n++) begin
         for (int i = 0; i < 8; i++) begin
            d = pdu_mem[n][i];
            exp_q.push_back(d ^ (WHITEN & w[6]));
            fb  = crc[23] ^ d;
            crc = {crc[22:0], 1'b0} ^ (fb ? 24'h00065B : 24'h000000);
            fb  = w[6];
            w   = {w[5:0], fb};
            w[4] = w[4] ^ fb;
         end
      end
      for (int i = 23; i >= 0; i--) begin
         exp_q.push_back(crc[i] ^ (WHITEN & w[6]));
         fb  = w[6];
         w   = {w[5:0], fb};
         w[4] = w[4] ^ fb;
      end
   endfunction

   function automatic int first_diff();
      for (int i = 0; i < cap_q.size(); i++) begin
         if (i >= exp_q.size()) return i;
         if (cap_q[i] !== exp_q[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic exp_at(input int i);
      if (i >= 0 && i < exp_q.size()) return exp_q[i];
      return 1'bx;
   endfunction

   function automatic logic cap_at(input int i);
      if (i >= 0 && i < cap_q.size()) return cap_q[i];
      return 1'bx;
   endfunction

   task automatic fill_random(input int len);
      for (int i = 0; i < len; i++) pdu_mem[i] = 8'($urandom_range(0, 255));
   endtask

   // Drives one frame request and observes the air interface until it ends.
   task automatic run_frame(input int len, input int period, input int withhold_idx,
                            input bit valid_always, input bit restart_mid,
                            input int rst_at_bit, input logic [5:0] chan);
      int idx, tail, budget;
      bit acc_prev, tick_prev, en_prev, done_prev, ended;
      cap_q.delete();
      n_done = 0; n_underrun = 0; n_bit_off_err = 0;
      timed_out = 0; saw_fall = 0; fall_done = 0; fall_underrun = 0;
      busy_at_done = 0; busy_after_done = 1;
      idx = 0; tail = 0; acc_prev = 0; tick_prev = 0; en_prev = 0; done_prev = 0; ended = 0;
      budget = (64 + 8 * len) * period + 60;
      for (int cyc = 0; cyc < budget; cyc++) begin
         @(negedge clk);
         if (acc_prev) idx++;
         if (tick_prev && tx_en) cap_q.push_back(tx_bit);
         if (!tx_en && tx_bit !== 1'b0) n_bit_off_err++;
         if (en_prev && !tx_en) begin
            saw_fall = 1; fall_done = done; fall_underrun = underrun;
         end
         if (done_prev) busy_after_done = busy;
         if (done) begin
            n_done++; busy_at_done = busy;
         end
         if (underrun) n_underrun++;
         done_prev = done;
         if (rst_at_bit > 0 && cap_q.size() == rst_at_bit) begin
            #2 rst = 1'b1;
            #1;
            ended = 1;
            break;
         end
         if (ended) begin
            tail++;
            if (tail > 3) break;
         end
         if (done || underrun) ended = 1;
         start    = (cyc == 0) || (restart_mid && cyc == budget / 2);
         pdu_len  = (cyc == 0) ? len[7:0] : 8'($urandom_range(0, 255));
         channel  = (cyc == 0) ? chan : 6'($urandom_range(0, 63));
         sym_tick = ((cyc % period) == 0);
         if (valid_always) begin
            byte_valid = 1'b1;
            byte_data  = (idx < len) ? pdu_mem[idx] : 8'($urandom_range(0, 255));
         end else begin
            byte_valid = (idx < len) && (idx != withhold_idx);
            byte_data  = byte_valid ? pdu_mem[idx] : 8'($urandom_range(0, 255));
         end
         acc_prev  = byte_valid && byte_ready;
         tick_prev = sym_tick;
         en_prev   = tx_en;
      end
      if (!ended) timed_out = 1;
      n_accepted = idx;
      start = 1'b0; byte_valid = 1'b0; sym_tick = 1'b0;
   endtask

   task automatic test_reset();
      int bad;
      rst = 1'b1; start = 1'b0; sym_tick = 1'b0; pdu_len = 8'd0; channel = 6'd0;
      byte_data = 8'h00; byte_valid = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if ({tx_bit, tx_en, busy, done, underrun, byte_ready} !== 6'b000000) begin
         tests_failed++;
         $display("FAIL reset_outputs got=%b exp=000000", {tx_bit, tx_en, busy, done, underrun, byte_ready});
      end
      rst = 1'b0;
      bad = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         sym_tick = (c % 2 == 0);
         if (tx_en || done || underrun || busy || tx_bit) bad++;
      end
      sym_tick = 1'b0;
      tests_run++;
      if (bad !== 0) begin
         tests_failed++;
         $display("FAIL reset_release_quiet got=%0d active cycles exp=0", bad);
      end
   endtask

   task automatic test_default_frame();
      int d;
      logic [5:0] ch;
      pdu_mem[0] = 8'h40; pdu_mem[1] = 8'h00;
      ch = 6'($urandom_range(0, 36));
      build_exp(2, ch);
      run_frame(2, 4, -1, 0, 0, 0, ch);
      tests_run++;
      if (cap_q.size() !== 80) begin
         tests_failed++; $display("FAIL default_bit_count got=%0d exp=80", cap_q.size());
      end
      tests_run++; d = first_diff();
      if (d != -1) begin
         tests_failed++; $display("FAIL default_stream bit %0d got=%b exp=%b", d, cap_at(d), exp_at(d));
      end
      tests_run++;
      if (n_done !== 1 || n_underrun !== 0 || timed_out) begin
         tests_failed++;
         $display("FAIL default_pulses got done=%0d underrun=%0d timeout=%0d exp done=1 underrun=0 timeout=0", n_done, n_underrun, timed_out);
      end
      tests_run++;
      if (!(saw_fall && fall_done)) begin
         tests_failed++; $display("FAIL default_done_on_fall got fall=%0d done=%0d exp fall=1 done=1", saw_fall, fall_done);
      end
      tests_run++;
      if (busy_at_done !== 1'b1 || busy_after_done !== 1'b0) begin
         tests_failed++;
         $display("FAIL default_busy_drop got at_done=%0d after=%0d exp at_done=1 after=0", busy_at_done, busy_after_done);
      end
      tests_run++;
      if (n_bit_off_err !== 0) begin
         tests_failed++; $display("FAIL default_bit_when_off got=%0d exp=0", n_bit_off_err);
      end
   endtask

   task automatic test_random_frames();
      int d, len, period;
      logic [5:0] ch;
      for (int k = 0; k < 6; k++) begin
         len    = $urandom_range(2, 24);
         period = $urandom_range(1, 5);
         ch     = 6'($urandom_range(0, 39));
         fill_random(len);
         build_exp(len, ch);
         run_frame(len, period, -1, 0, 0, 0, ch);
         tests_run++;
         if (cap_q.size() !== 64 + 8 * len) begin
            tests_failed++; $display("FAIL random_bit_count L=%0d got=%0d exp=%0d", len, cap_q.size(), 64 + 8 * len);
         end
         tests_run++; d = first_diff();
         if (d != -1) begin
            tests_failed++; $display("FAIL random_stream L=%0d bit %0d got=%b exp=%b", len, d, cap_at(d), exp_at(d));
         end
         tests_run++;
         if (n_done !== 1 || n_underrun !== 0 || n_accepted !== len || timed_out) begin
            tests_failed++;
            $display("FAIL random_pulses L=%0d got done=%0d underrun=%0d bytes=%0d exp done=1 underrun=0 bytes=%0d", len, n_done, n_underrun, n_accepted, len);
         end
      end
   endtask

   task automatic test_underrun();
      int d;
      logic [5:0] ch;
      ch = 6'($urandom_range(0, 39));
      fill_random(5);
      build_exp(5, ch);
      run_frame(5, 4, 3, 0, 0, 0, ch);
      tests_run++;
      if (cap_q.size() !== 64) begin
         tests_failed++; $display("FAIL underrun_bit_count got=%0d exp=64", cap_q.size());
      end
      tests_run++; d = first_diff();
      if (d != -1) begin
         tests_failed++; $display("FAIL underrun_prefix bit %0d got=%b exp=%b", d, cap_at(d), exp_at(d));
      end
      tests_run++;
      if (n_underrun !== 1 || n_done !== 0 || !fall_underrun || timed_out) begin
         tests_failed++;
         $display("FAIL underrun_pulses got underrun=%0d done=%0d on_fall=%0d exp underrun=1 done=0 on_fall=1", n_underrun, n_done, fall_underrun);
      end
      fill_random(3);
      build_exp(3, ch);
      run_frame(3, 4, -1, 0, 0, 0, ch);
      tests_run++; d = first_diff();
      if (d != -1 || cap_q.size() !== 88 || n_done !== 1) begin
         tests_failed++;
         $display("FAIL underrun_next_frame got bits=%0d diff=%0d done=%0d exp bits=88 diff=-1 done=1", cap_q.size(), d, n_done);
      end
   endtask

   task automatic test_reset_mid();
      int d, bad;
      logic [5:0] ch;
      ch = 6'($urandom_range(0, 39));
      fill_random(4);
      run_frame(4, 3, -1, 0, 0, 19, ch);
      tests_run++;
      if ({tx_bit, tx_en, busy, done, underrun, byte_ready} !== 6'b000000) begin
         tests_failed++;
         $display("FAIL reset_mid_outputs got=%b exp=000000", {tx_bit, tx_en, busy, done, underrun, byte_ready});
      end
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         sym_tick = (c % 2 == 0);
         if (tx_en || done || underrun || busy) bad++;
      end
      sym_tick = 1'b0;
      tests_run++;
      if (bad !== 0) begin
         tests_failed++; $display("FAIL reset_mid_release got=%0d active cycles exp=0", bad);
      end
      fill_random(3);
      build_exp(3, ch);
      run_frame(3, 2, -1, 0, 0, 0, ch);
      tests_run++; d = first_diff();
      if (d != -1 || cap_q.size() !== 88 || n_done !== 1) begin
         tests_failed++;
         $display("FAIL reset_mid_fresh_frame got bits=%0d diff=%0d done=%0d exp bits=88 diff=-1 done=1", cap_q.size(), d, n_done);
      end
   endtask

   task automatic test_short_len();
      int bad;
      for (int k = 0; k < 2; k++) begin
         bad = 0;
         for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy || tx_en || byte_ready) bad++;
            start      = (c < 3);
            pdu_len    = 8'(k);
            sym_tick   = (c % 2 == 0);
            byte_valid = 1'b1;
            byte_data  = 8'($urandom_range(0, 255));
         end
         start = 1'b0; byte_valid = 1'b0; sym_tick = 1'b0;
         tests_run++;
         if (bad !== 0) begin
            tests_failed++; $display("FAIL short_len L=%0d got=%0d active cycles exp=0", k, bad);
         end
      end
   endtask

   task automatic test_restart_mid();
      int d, len;
      logic [5:0] ch;
      len = $urandom_range(3, 10);
      ch  = 6'($urandom_range(0, 39));
      fill_random(len);
      build_exp(len, ch);
      run_frame(len, 2, -1, 1, 1, 0, ch);
      tests_run++;
      if (n_accepted !== len) begin
         tests_failed++; $display("FAIL restart_bytes_taken got=%0d exp=%0d", n_accepted, len);
      end
      tests_run++; d = first_diff();
      if (d != -1 || cap_q.size() !== 64 + 8 * len || n_done !== 1) begin
         tests_failed++;
         $display("FAIL restart_frame got bits=%0d diff=%0d done=%0d exp bits=%0d diff=-1 done=1", cap_q.size(), d, n_done, 64 + 8 * len);
      end
   endtask

   task automatic test_whiten_ch37();
      int d;
      fill_random(2);
      build_exp(2, 6'd37);
      run_frame(2, 4, -1, 0, 0, 0, 6'd37);
      tests_run++; d = first_diff();
      if (d != -1 || cap_q.size() !== 80) begin
         tests_failed++;
         $display("FAIL ch37_stream got bits=%0d diff=%0d exp bits=80 diff=-1", cap_q.size(), d);
      end
`ifdef BLE_TX_WHITEN_EN
      tests_run++;
      if (cap_at(40) !== (pdu_mem[0][0] ^ 1'b1)) begin
         tests_failed++; $display("FAIL ch37_first_white_bit got=%b exp=%b", cap_at(40), pdu_mem[0][0] ^ 1'b1);
      end
`else
      tests_run++;
      if (cap_at(40) !== pdu_mem[0][0]) begin
         tests_failed++; $display("FAIL ch37_first_plain_bit got=%b exp=%b", cap_at(40), pdu_mem[0][0]);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_default_frame();
      test_random_frames();
      test_underrun();
      test_reset_mid();
      test_short_len();
      test_restart_mid();
      test_whiten_ch37();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/ble_tx_packetizer.md
BLE_TX_PACKETIZER -- requirements
Module: ble_tx_packetizer

Interface
REQ-001 Parameter ACCESS_ADDR, default 32'h8E89BED6, access address transmitted after the preamble.
REQ-002 Parameter CRC_INIT, default 24'h555555, CRC register seed.
REQ-003 clk  input  1  single clock for all logic; every register is on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 sym_tick  input  1  one-cycle strobe, one per bit period.
REQ-006 start  input  1  frame request, sampled only in IDLE.
REQ-007 pdu_len  input  8  PDU byte count including the 2-byte header, latched on start.
REQ-008 channel  input  6  RF channel index, latched on start; seeds whitening.
REQ-009 byte_data  input  8  next PDU byte.
REQ-010 byte_valid  input  1  byte_data is valid.
REQ-011 byte_ready  output  1  block can accept a byte this cycle.
REQ-012 tx_bit  output  1  serial air bit, driven to the modulator.
REQ-013 tx_en  output  1  high while a frame is on air.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse when a frame completes normally.
REQ-016 underrun  output  1  one-cycle pulse when a frame is aborted.

Function
REQ-017 The block SHALL implement the states IDLE, PRE (8 bits), AA (32 bits), PDU (8*L bits) and CRC (24 bits), where L is the latched pdu_len.
REQ-018 The block SHALL go from IDLE to PRE when start=1 and pdu_len>=2; when start=1 and pdu_len<2 it SHALL ignore start.
REQ-019 tx_bit and the bit counters SHALL change only on clk edges where sym_tick=1; tx_en SHALL rise on the first such edge after entering PRE and fall on the sym_tick edge after the last CRC bit.
REQ-020 The preamble SHALL be 8'hAA when ACCESS_ADDR[0]=0 and 8'h55 otherwise, so that its first bit equals ACCESS_ADDR[0].
REQ-021 Preamble, access address and PDU bytes SHALL each be sent LSB first.
REQ-022 CRC: for each PDU bit d (before whitening), fb=crc[23]^d; crc={crc[22:0],1'b0}^(fb?24'h00065B:0); crc SHALL be seeded with CRC_INIT at the PRE entry.
REQ-023 The CRC field SHALL be sent crc[23] first, shifting left.
REQ-024 A one-byte holding buffer SHALL decouple the byte input; byte_ready=1 iff the buffer is empty, the state is PRE/AA/PDU, and bytes_requested<L; a byte is taken when byte_valid&&byte_ready.
REQ-025 At each PDU byte boundary, if the buffer is empty the block SHALL abort: pulse underrun, drive tx_en=0 and tx_bit=0, return to IDLE, and leave done unasserted.
REQ-026 done SHALL pulse in the same cycle that tx_en falls; busy SHALL drop in the next cycle.
REQ-027 Total on-air bits per frame SHALL be 64+8*L.
REQ-028 start, byte_valid without byte_ready, and any input changes other than byte transfers SHALL be ignored while busy=1.
REQ-029 tx_bit SHALL be 0 whenever tx_en=0.

Reset
REQ-030 rst=1 SHALL immediately force IDLE with tx_bit=0, tx_en=0, busy=0, done=0, underrun=0, byte_ready=0, the buffer empty and all counters zero, including mid-frame; no pulse SHALL be emitted on release.

Configuration
REQ-031 With macro BLE_TX_WHITEN_EN defined, the PDU and CRC bits SHALL be XORed with w[6] of a 7-bit LFSR w seeded {1'b1,channel} at PRE entry; per PDU/CRC bit, w is rotated left and the old w[6] is XORed into the new w[4] (x^7+x^4+1).
REQ-032 Without BLE_TX_WHITEN_EN, the PDU and CRC bits SHALL be sent unwhitened and the channel input SHALL be unused.

Verification
REQ-033 Default AA, L=2, whitening off, bytes 0x40,0x00 supplied promptly, sym_tick every 4 clk -> 80 bits: 0xAA then 0x8E89BED6 LSB-first, then 0x40,0x00 LSB-first, then 24 CRC bits matching a bit-serial model of REQ-022; one done pulse.
REQ-034 L=5 and byte_valid withheld for the 4th byte -> underrun pulses at the bit-24 PDU boundary, tx_en drops, no done; the next start works normally.
REQ-035 rst asserted during AA bit 10 -> all outputs are 0 within the same cycle, state IDLE; a fresh frame afterwards is bit-exact.
REQ-036 start with pdu_len=1 -> busy stays 0 and tx_en never rises.
REQ-037 BLE_TX_WHITEN_EN defined, channel=37, L=2 -> the PDU/CRC bits equal the unwhitened stream XOR the model LFSR; the first whitening bit is 1.
REQ-038 start pulsed again mid-frame and byte_valid held high continuously -> exactly L bytes are accepted and the frame is unaffected.
